// File: rtl/diff_core_pkg.sv
// diff_core_pkg
//    Shared types and constants for the diffusion core datapath.
//    PE_weight_t is the packed kernel handed to every PE: a 5*5 kernel is
//    split into A_9 (words 0-8), B_6 (9-14), C_6 (15-20) and D_4 (21-24).
//    A 3*3 kernel only uses A_9; the other fields are zero.
package diff_core_pkg;

   parameter int BIT_WIDTH = 8;

   parameter int K3_WORDS = 9;
   parameter int K5_WORDS = 25;

   typedef enum logic {K3X3 = 1'b0, K5X5 = 1'b1} kernel_mode_t;

   typedef struct packed {
      logic [8:0][BIT_WIDTH-1:0] A_9;
      logic [5:0][BIT_WIDTH-1:0] B_6;
      logic [5:0][BIT_WIDTH-1:0] C_6;
      logic [3:0][BIT_WIDTH-1:0] D_4;
   } PE_weight_t;

endpackage

// File: rtl/pe_weight_packer.sv
// pe_weight_packer
//    Producer end of the PE_weight_t interface. Raw kernel weights arrive one
//    word per handshake in row-major order, are collected in an assembly
//    register and then moved to an output register that is offered to the PE
//    row with valid/ready. The two stages let input streaming continue while
//    the PE stalls on the previous kernel.
//
//    Parameters
//       KCNT_W          width of the delivered-kernel counter (wraps)
//       (word width is BIT_WIDTH from diff_core_pkg, fixed by PE_weight_t)
//
//    Ports
//       clk, rst_n       clock, asynchronous active-low reset
//       clear            synchronous soft clear, drops partial and output kernel
//       cfg_kernel_mode  0: 3*3 (9 words), 1: 5*5 (25 words)
//       in_valid/ready   weight word handshake, in_data is the word
//       out_valid/ready  packed kernel handshake, out_weight is the kernel
//       out_mode         kernel mode latched for the kernel on out_weight
//       kernel_cnt       kernels consumed by the PE
//       out_zero         (WT_PACK_ZERO_SKIP_EN only) every weight of the
//                        kernel on out_weight is zero
//
//    Build option
//       WT_PACK_ZERO_SKIP_EN  adds out_zero and its incremental zero tracking
module pe_weight_packer
   import diff_core_pkg::*;
#(
   parameter int KCNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 cfg_kernel_mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output PE_weight_t           out_weight,
   output logic                 out_mode,
   output logic [KCNT_W-1:0]    kernel_cnt
`ifdef WT_PACK_ZERO_SKIP_EN
   ,
   output logic                 out_zero
`endif
);

   localparam int WCNT_W = $clog2(K5_WORDS);
   localparam logic [WCNT_W-1:0] K3Last = WCNT_W'(K3_WORDS - 1);
   localparam logic [WCNT_W-1:0] K5Last = WCNT_W'(K5_WORDS - 1);
   localparam int BBase = 9;
   localparam int CBase = 15;
   localparam int DBase = 21;

   logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
   kernel_mode_t         asmMode_q, asmMode_d;
   logic                 asmPending_q, asmPending_d;
   logic [BIT_WIDTH-1:0] asmWords_q [K5_WORDS];
   logic                 outValid_q, outValid_d;
   PE_weight_t           outWeight_q, outWeight_d;
   kernel_mode_t         outMode_q, outMode_d;
   logic [KCNT_W-1:0]    kernelCnt_q, kernelCnt_d;
   logic                 readyEn_q;

   logic                 inHs;
   logic                 xfer;
   logic                 consume;
   logic                 lastWord;
   kernel_mode_t         curMode;
   PE_weight_t           xferWeight;

`ifdef WT_PACK_ZERO_SKIP_EN
   logic                 asmZero_q, asmZero_d;
   logic                 outZero_q, outZero_d;
`endif

   // Handshake qualifiers. readyEn_q keeps in_ready low while in reset and
   // for the first edge after it. A word can be taken while the assembled
   // kernel is leaving in the same cycle, which removes the bubble between
   // back-to-back kernels.
   always_comb begin
      xfer     = asmPending_q & (~outValid_q | out_ready);
      consume  = outValid_q & out_ready;
      in_ready = readyEn_q & (~asmPending_q | xfer);
      inHs     = in_valid & in_ready;
   end

   // The kernel mode is taken from the config input only on word 0; after
   // that the latched mode decides the kernel length, so mid-kernel config
   // changes have no effect.
   always_comb begin
      curMode  = (wcnt_q == '0) ? kernel_mode_t'(cfg_kernel_mode) : asmMode_q;
      lastWord = (curMode == K5X5) ? (wcnt_q == K5Last) : (wcnt_q == K3Last);
   end

   // Builds the outgoing struct from the assembly words. The assembly words
   // are not cleared between kernels, so a 3*3 kernel must mask the fields
   // that may still hold words of an earlier 5*5 kernel.
   always_comb begin
      xferWeight = '0;
      for (int i = 0; i < K3_WORDS; i++) begin
         xferWeight.A_9[i] = asmWords_q[i];
      end
      if (asmMode_q == K5X5) begin
         for (int i = 0; i < 6; i++) begin
            xferWeight.B_6[i] = asmWords_q[BBase + i];
            xferWeight.C_6[i] = asmWords_q[CBase + i];
         end
         for (int i = 0; i < 4; i++) begin
            xferWeight.D_4[i] = asmWords_q[DBase + i];
         end
      end
   end

   // Next-state for counters, assembly status and the output stage. A soft
   // clear overrides everything that happens in the same cycle, including a
   // word handshake.
   always_comb begin
      wcnt_d       = wcnt_q;
      asmMode_d    = asmMode_q;
      asmPending_d = asmPending_q;
      outValid_d   = outValid_q;
      outWeight_d  = outWeight_q;
      outMode_d    = outMode_q;
      kernelCnt_d  = kernelCnt_q;
`ifdef WT_PACK_ZERO_SKIP_EN
      asmZero_d    = asmZero_q;
      outZero_d    = outZero_q;
`endif

      if (xfer) begin
         asmPending_d = 1'b0;
         outValid_d   = 1'b1;
         outWeight_d  = xferWeight;
         outMode_d    = asmMode_q;
`ifdef WT_PACK_ZERO_SKIP_EN
         outZero_d    = asmZero_q;
`endif
      end else if (consume) begin
         outValid_d = 1'b0;
      end

      if (consume) begin
         kernelCnt_d = kernelCnt_q + 1'b1;
      end

      if (inHs) begin
         asmMode_d = curMode;
`ifdef WT_PACK_ZERO_SKIP_EN
         asmZero_d = ((wcnt_q == '0) ? 1'b1 : asmZero_q) & (in_data == '0);
`endif
         if (lastWord) begin
            asmPending_d = 1'b1;
            wcnt_d       = '0;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
         end
      end

      if (clear) begin
         wcnt_d       = '0;
         asmMode_d    = K3X3;
         asmPending_d = 1'b0;
         outValid_d   = 1'b0;
         outWeight_d  = '0;
         outMode_d    = K3X3;
         kernelCnt_d  = '0;
`ifdef WT_PACK_ZERO_SKIP_EN
         asmZero_d    = 1'b0;
         outZero_d    = 1'b0;
`endif
      end
   end

   // Control and output stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_q       <= '0;
         asmMode_q    <= K3X3;
         asmPending_q <= 1'b0;
         outValid_q   <= 1'b0;
         outWeight_q  <= '0;
         outMode_q    <= K3X3;
         kernelCnt_q  <= '0;
         readyEn_q    <= 1'b0;
`ifdef WT_PACK_ZERO_SKIP_EN
         asmZero_q    <= 1'b0;
         outZero_q    <= 1'b0;
`endif
      end else begin
         wcnt_q       <= wcnt_d;
         asmMode_q    <= asmMode_d;
         asmPending_q <= asmPending_d;
         outValid_q   <= outValid_d;
         outWeight_q  <= outWeight_d;
         outMode_q    <= outMode_d;
         kernelCnt_q  <= kernelCnt_d;
         readyEn_q    <= 1'b1;
`ifdef WT_PACK_ZERO_SKIP_EN
         asmZero_q    <= asmZero_d;
         outZero_q    <= outZero_d;
`endif
      end
   end

   // Assembly word storage: each accepted word lands at its row-major
   // position, which is also its position in the flattened PE_weight_t.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < K5_WORDS; i++) begin
            asmWords_q[i] <= '0;
         end
      end else if (inHs && !clear) begin
         asmWords_q[wcnt_q] <= in_data;
      end
   end

   always_comb begin
      out_valid  = outValid_q;
      out_weight = outWeight_q;
      out_mode   = outMode_q;
      kernel_cnt = kernelCnt_q;
`ifdef WT_PACK_ZERO_SKIP_EN
      out_zero   = outZero_q;
`endif
   end

endmodule

// File: tb/tb_pe_weight_packer.sv
// tb_pe_weight_packer
//    Directed bench for pe_weight_packer. Inputs change 1 time unit after the
//    rising edge and outputs are sampled at that same point.
module tb_pe_weight_packer;
   import diff_core_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             cfg_kernel_mode;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             out_valid;
   logic             out_ready;
   PE_weight_t       out_weight;
   logic             out_mode;
   logic [15:0]      kernel_cnt;
`ifdef WT_PACK_ZERO_SKIP_EN
   logic             out_zero;
`endif

   int testsRun;
   int testsFailed;
   int expKcnt;

   pe_weight_packer #(.KCNT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear),
      .cfg_kernel_mode(cfg_kernel_mode),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_weight     (out_weight),
      .out_mode       (out_mode),
      .kernel_cnt     (kernel_cnt)
`ifdef WT_PACK_ZERO_SKIP_EN
      ,
      .out_zero       (out_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one word and returns after the edge where it was accepted.
   // in_valid stays high so callers can stream words back to back.
   task automatic sendWord(input logic [7:0] data, input logic mode, output int stalls);
      stalls = 0;
      in_valid = 1'b1;
      in_data = data;
      cfg_kernel_mode = mode;
      while (!in_ready && stalls < 50) begin
         tick();
         stalls++;
      end
      if (!in_ready) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL sendWord_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, stalls);
      end
      tick();
   endtask

   task automatic sendKernel(input int nWords, input int base, input logic mode);
      int s;
      for (int i = 0; i < nWords; i++) begin
         sendWord(8'(base + i), mode, s);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; cfg_kernel_mode = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      testsRun++;
      if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %0b, required 0", in_ready); end
      testsRun++;
      if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid); end
      testsRun++;
      if (kernel_cnt !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_kernel_cnt: got %0d, required 0", kernel_cnt); end
      testsRun++;
      if (out_weight !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_weight: got %h, required 0", out_weight); end
      rst_n = 1'b1;
      tick();
      testsRun++;
      if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_in_ready: got %0b, required 1", in_ready); end
   endtask

   task automatic test_3x3();
      out_ready = 1'b1;
      sendKernel(9, 1, 1'b0);
      testsRun++;
      if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL k3_latency_early: out_valid=%0b, required 0", out_valid); end
      tick();
      testsRun++;
      if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL k3_out_valid: got %0b, required 1", out_valid); end
      for (int i = 0; i < 9; i++) begin
         testsRun++;
         if (out_weight.A_9[i] !== 8'(i + 1)) begin
            testsFailed++;
            $display("[TB] FAIL k3_A9[%0d]: got %0d, required %0d", i, out_weight.A_9[i], i + 1);
         end
      end
      testsRun++;
      if ({out_weight.B_6, out_weight.C_6, out_weight.D_4} !== '0) begin
         testsFailed++; $display("[TB] FAIL k3_BCD_zero: got %h, required 0", {out_weight.B_6, out_weight.C_6, out_weight.D_4});
      end
      testsRun++;
      if (out_mode !== 1'b0) begin testsFailed++; $display("[TB] FAIL k3_out_mode: got %0b, required 0", out_mode); end
      tick();
      expKcnt = 1;
      testsRun++;
      if (kernel_cnt !== 16'(expKcnt)) begin testsFailed++; $display("[TB] FAIL k3_kernel_cnt: got %0d, required %0d", kernel_cnt, expKcnt); end
      testsRun++;
      if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL k3_out_valid_drop: got %0b, required 0", out_valid); end
   endtask

   task automatic test_5x5();
      out_ready = 1'b1;
      sendKernel(25, 1, 1'b1);
      tick();
      testsRun++;
      if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL k5_out_valid: got %0b, required 1", out_valid); end
      for (int i = 0; i < 9; i++) begin
         testsRun++;
         if (out_weight.A_9[i] !== 8'(i + 1)) begin testsFailed++; $display("[TB] FAIL k5_A9[%0d]: got %0d, required %0d", i, out_weight.A_9[i], i + 1); end
      end
      for (int i = 0; i < 6; i++) begin
         testsRun++;
         if (out_weight.B_6[i] !== 8'(i + 10)) begin testsFailed++; $display("[TB] FAIL k5_B6[%0d]: got %0d, required %0d", i, out_weight.B_6[i], i + 10); end
         testsRun++;
         if (out_weight.C_6[i] !== 8'(i + 16)) begin testsFailed++; $display("[TB] FAIL k5_C6[%0d]: got %0d, required %0d", i, out_weight.C_6[i], i + 16); end
      end
      for (int i = 0; i < 4; i++) begin
         testsRun++;
         if (out_weight.D_4[i] !== 8'(i + 22)) begin testsFailed++; $display("[TB] FAIL k5_D4[%0d]: got %0d, required %0d", i, out_weight.D_4[i], i + 22); end
      end
      testsRun++;
      if (out_mode !== 1'b1) begin testsFailed++; $display("[TB] FAIL k5_out_mode: got %0b, required 1", out_mode); end
      tick();
      expKcnt = 2;
      testsRun++;
      if (kernel_cnt !== 16'(expKcnt)) begin testsFailed++; $display("[TB] FAIL k5_kernel_cnt: got %0d, required %0d", kernel_cnt, expKcnt); end
   endtask

   task automatic test_back_to_back();
      int s;
      int totalStalls;
      int cycles;
      totalStalls = 0;
      cycles = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 75; i++) begin
         sendWord(8'(i + 1), 1'b1, s);
         totalStalls += s;
         cycles += s + 1;
      end
      in_valid = 1'b0;
      testsRun++;
      if (totalStalls !== 0) begin testsFailed++; $display("[TB] FAIL b2b_stalls: got %0d stall cycles, required 0", totalStalls); end
      testsRun++;
      if (cycles !== 75) begin testsFailed++; $display("[TB] FAIL b2b_cycles: got %0d, required 75", cycles); end
      tick();
      testsRun++;
      if (out_valid !== 1'b1 || out_weight.A_9[0] !== 8'd51 || out_weight.D_4[3] !== 8'd75) begin
         testsFailed++;
         $display("[TB] FAIL b2b_last_kernel: valid=%0b A0=%0d D3=%0d, required 1/51/75", out_valid, out_weight.A_9[0], out_weight.D_4[3]);
      end
      tick();
      expKcnt += 3;
      testsRun++;
      if (kernel_cnt !== 16'(expKcnt)) begin testsFailed++; $display("[TB] FAIL b2b_kernel_cnt: got %0d, required %0d", kernel_cnt, expKcnt); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      sendKernel(9, 10, 1'b0);
      sendKernel(9, 20, 1'b0);
      for (int c = 0; c < 3; c++) begin
         testsRun++;
         if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_in_ready[%0d]: got %0b, required 0", c, in_ready); end
         testsRun++;
         if (out_valid !== 1'b1 || out_weight.A_9[0] !== 8'd10 || out_weight.A_9[8] !== 8'd18) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold[%0d]: valid=%0b A0=%0d A8=%0d, required 1/10/18", c, out_valid, out_weight.A_9[0], out_weight.A_9[8]);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      expKcnt += 1;
      testsRun++;
      if (out_valid !== 1'b1 || out_weight.A_9[0] !== 8'd20 || out_weight.A_9[8] !== 8'd28) begin
         testsFailed++;
         $display("[TB] FAIL bp_second: valid=%0b A0=%0d A8=%0d, required 1/20/28", out_valid, out_weight.A_9[0], out_weight.A_9[8]);
      end
      testsRun++;
      if (kernel_cnt !== 16'(expKcnt)) begin testsFailed++; $display("[TB] FAIL bp_cnt_first: got %0d, required %0d", kernel_cnt, expKcnt); end
      tick();
      expKcnt += 1;
      testsRun++;
      if (out_valid !== 1'b0 || kernel_cnt !== 16'(expKcnt)) begin
         testsFailed++;
         $display("[TB] FAIL bp_drain: valid=%0b cnt=%0d, required 0/%0d", out_valid, kernel_cnt, expKcnt);
      end
   endtask

   task automatic test_mode_switch();
      int s;
      out_ready = 1'b1;
      for (int i = 0; i < 25; i++) begin
         sendWord(8'(i + 1), (i < 5) ? 1'b1 : 1'b0, s);
      end
      in_valid = 1'b0;
      tick();
      testsRun++;
      if (out_valid !== 1'b1 || out_mode !== 1'b1 || out_weight.D_4[3] !== 8'd25 || out_weight.B_6[0] !== 8'd10) begin
         testsFailed++;
         $display("[TB] FAIL ms_kernel: valid=%0b mode=%0b D3=%0d B0=%0d, required 1/1/25/10", out_valid, out_mode, out_weight.D_4[3], out_weight.B_6[0]);
      end
      sendKernel(9, 101, 1'b0);
      tick();
      testsRun++;
      if (out_valid !== 1'b1 || out_mode !== 1'b0 || out_weight.A_9[0] !== 8'd101 || out_weight.A_9[8] !== 8'd109) begin
         testsFailed++;
         $display("[TB] FAIL ms_next: valid=%0b mode=%0b A0=%0d A8=%0d, required 1/0/101/109", out_valid, out_mode, out_weight.A_9[0], out_weight.A_9[8]);
      end
      testsRun++;
      if ({out_weight.B_6, out_weight.C_6, out_weight.D_4} !== '0) begin
         testsFailed++; $display("[TB] FAIL ms_mask: got %h, required 0", {out_weight.B_6, out_weight.C_6, out_weight.D_4});
      end
      tick();
      expKcnt += 2;
      testsRun++;
      if (kernel_cnt !== 16'(expKcnt)) begin testsFailed++; $display("[TB] FAIL ms_kernel_cnt: got %0d, required %0d", kernel_cnt, expKcnt); end
   endtask

   task automatic test_clear();
      out_ready = 1'b0;
      sendKernel(9, 1, 1'b0);
      tick();
      sendKernel(12, 30, 1'b1);
      in_valid = 1'b1;
      in_data = 8'd77;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      testsRun++;
      if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL clr_out_valid: got %0b, required 0", out_valid); end
      testsRun++;
      if (out_weight !== '0) begin testsFailed++; $display("[TB] FAIL clr_out_weight: got %h, required 0", out_weight); end
      testsRun++;
      if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL clr_in_ready: got %0b, required 1", in_ready); end
      out_ready = 1'b1;
      sendKernel(9, 201, 1'b0);
      tick();
      testsRun++;
      if (out_valid !== 1'b1 || out_mode !== 1'b0 || out_weight.A_9[0] !== 8'd201 || out_weight.A_9[8] !== 8'd209) begin
         testsFailed++;
         $display("[TB] FAIL clr_next: valid=%0b mode=%0b A0=%0d A8=%0d, required 1/0/201/209", out_valid, out_mode, out_weight.A_9[0], out_weight.A_9[8]);
      end
      testsRun++;
      if ({out_weight.B_6, out_weight.C_6, out_weight.D_4} !== '0) begin
         testsFailed++; $display("[TB] FAIL clr_mask: got %h, required 0", {out_weight.B_6, out_weight.C_6, out_weight.D_4});
      end
      tick();
   endtask

`ifdef WT_PACK_ZERO_SKIP_EN
   task automatic test_zero_skip();
      int s;
      out_ready = 1'b1;
      sendKernel(9, 0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         sendWord('0, 1'b0, s);
      end
      in_valid = 1'b0;
      tick();
      testsRun++;
      if (out_valid !== 1'b1 || out_zero !== 1'b1) begin testsFailed++; $display("[TB] FAIL zs_all_zero: valid=%0b zero=%0b, required 1/1", out_valid, out_zero); end
      for (int i = 0; i < 9; i++) begin
         sendWord((i == 4) ? 8'd5 : 8'd0, 1'b0, s);
      end
      in_valid = 1'b0;
      tick();
      testsRun++;
      if (out_valid !== 1'b1 || out_zero !== 1'b0) begin testsFailed++; $display("[TB] FAIL zs_nonzero: valid=%0b zero=%0b, required 1/0", out_valid, out_zero); end
      tick();
   endtask
`endif

   initial begin
      testsRun = 0;
      testsFailed = 0;
      expKcnt = 0;
      test_reset();
      test_3x3();
      test_5x5();
      test_back_to_back();
      test_backpressure();
      test_mode_switch();
      test_clear();
`ifdef WT_PACK_ZERO_SKIP_EN
      test_zero_skip();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
